// File: rtl/request_heartbeat_mc.sv
`timescale 1ns/1ps
// Multi-channel heartbeat requester: issues per-channel requests, waits for acks with a bounded
// timeout and tracks consecutive misses into a sticky-until-ack fault flag.
//
// state  | meaning
// IDLE   | waiting for start or an expired period timer with auto_en
// REQ    | latch channel mask, arm timeout and period timers, raise req
// WAIT   | collect acks until all enabled channels seen or timeout
// DONE   | pulse done, bump round count, update alive/miss/fault
module request_heartbeat_mc #(
  parameter int NUM_CH      = 4,
  parameter int PERIOD      = 1000,
  parameter int TIMEOUT_CYC = 64,
  parameter int MISS_LIMIT  = 3,
  parameter int RESULT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                auto_en,
  input  logic [NUM_CH-1:0]   en_mask,
  input  logic [NUM_CH-1:0]   ack,
  output logic [NUM_CH-1:0]   req,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] result,
  output logic [NUM_CH-1:0]   alive,
  output logic [NUM_CH-1:0]   fault
);

  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int PER_W  = $clog2(PERIOD);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   mask_r;
  logic [NUM_CH-1:0]   seen;
  logic [NUM_CH-1:0]   hit;
  logic [NUM_CH-1:0]   seen_nxt;
  logic [TO_W-1:0]     to_cnt;
  logic [PER_W-1:0]    timer;
  logic [MISS_W-1:0]   miss [NUM_CH];
  logic                launch;
  logic                wait_exit;

  // An ack only counts against a request that is still outstanding.
  assign hit       = ack & req;
  assign seen_nxt  = seen | hit;
  assign wait_exit = (&seen_nxt) || (to_cnt == '0);
  assign launch    = start || (auto_en && (timer == '0));

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  if (wait_exit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r <= '0;
      seen   <= '0;
      req    <= '0;
      to_cnt <= '0;
      timer  <= '0;
      result <= '0;
      alive  <= '0;
      fault  <= '0;
      for (int i = 0; i < NUM_CH; i++) miss[i] <= '0;
    end else begin
      if (state == S_REQ)      timer <= PER_W'(PERIOD - 1);
      else if (timer != '0)    timer <= timer - 1'b1;

      case (state)
        S_REQ: begin
          mask_r <= en_mask;
          seen   <= ~en_mask;
          to_cnt <= TO_W'(TIMEOUT_CYC - 1);
          req    <= en_mask;
        end
        S_WAIT: begin
          seen <= seen_nxt;
          if (wait_exit) begin
            req <= '0;
          end else begin
            req    <= req & ~hit;
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_DONE: begin
          result <= result + 1'b1;
          alive  <= seen;
          // Miss count saturates at the limit; fault then stays set until an ack.
          for (int i = 0; i < NUM_CH; i++) begin
            if (mask_r[i]) begin
              if (seen[i]) begin
                miss[i]  <= '0;
                fault[i] <= 1'b0;
              end else if (miss[i] != MISS_W'(MISS_LIMIT)) begin
                miss[i] <= miss[i] + 1'b1;
                if (miss[i] + 1'b1 == MISS_W'(MISS_LIMIT)) fault[i] <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_request_heartbeat_mc.sv
`timescale 1ns/1ps
// Directed bench for request_heartbeat_mc: latency, timeout/miss/fault, masking, wrap,
// async reset and periodic auto launch, checked with immediate assertions.
module tb_request_heartbeat_mc;

  localparam int NUM_CH      = 4;
  localparam int PERIOD      = 1000;
  localparam int TIMEOUT_CYC = 64;
  localparam int MISS_LIMIT  = 3;
  localparam int RESULT_W    = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                auto_en;
  logic [NUM_CH-1:0]   en_mask;
  logic [NUM_CH-1:0]   ack;
  logic [NUM_CH-1:0]   req;
  logic                busy;
  logic                done;
  logic [RESULT_W-1:0] result;
  logic [NUM_CH-1:0]   alive;
  logic [NUM_CH-1:0]   fault;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  request_heartbeat_mc #(
    .NUM_CH(NUM_CH), .PERIOD(PERIOD), .TIMEOUT_CYC(TIMEOUT_CYC),
    .MISS_LIMIT(MISS_LIMIT), .RESULT_W(RESULT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en),
    .en_mask(en_mask), .ack(ack), .req(req), .busy(busy), .done(done),
    .result(result), .alive(alive), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One software-launched round; returns cycles from start to done, WAIT cycles with any req,
  // and the OR of all req values seen. Leaves the FSM back in IDLE.
  task automatic round(input logic [3:0] m, input logic [3:0] a,
                       output int lat, output int reqc, output logic [3:0] req_or);
    en_mask = m;
    ack     = a;
    start   = 1'b1;
    reqc    = 0;
    req_or  = '0;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 300) begin
      if (req != '0) reqc++;
      req_or |= req;
      tick();
      lat++;
    end
    if (!done) chk("round_timeout", 32'(lat), 32'(0));
    tick();
  endtask

  int          lat, reqc, r1, r2;
  logic [3:0]  ror;

  initial begin
    rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; en_mask = '0; ack = '0;
    repeat (3) tick();
    chk("rst_req",    32'(req),    32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_result", 32'(result), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy",  32'(busy),   32'h0);

    // 1: all acks high, minimum latency
    en_mask = 4'hF; ack = 4'hF; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_c1_busy", 32'(busy), 32'h1);
    chk("t1_c1_req",  32'(req),  32'h0);
    tick();
    chk("t1_c2_req",  32'(req),  32'hF);
    chk("t1_c2_done", 32'(done), 32'h0);
    tick();
    chk("t1_c3_done", 32'(done), 32'h1);
    chk("t1_c3_req",  32'(req),  32'h0);
    chk("t1_c3_busy", 32'(busy), 32'h1);
    tick();
    chk("t1_c4_done",   32'(done),   32'h0);
    chk("t1_c4_busy",   32'(busy),   32'h0);
    chk("t1_result",    32'(result), 32'h1);
    chk("t1_alive",     32'(alive),  32'hF);

    // 2: ch2 never acks -> full timeout, fault after three misses
    round(4'hF, 4'hB, lat, reqc, ror);
    chk("t2_lat",    32'(lat),   32'd66);
    chk("t2_reqc",   32'(reqc),  32'd64);
    chk("t2_alive",  32'(alive), 32'hB);
    chk("t2_fault1", 32'(fault), 32'h0);
    round(4'hF, 4'hB, lat, reqc, ror);
    chk("t2_fault2", 32'(fault), 32'h0);
    round(4'hF, 4'hB, lat, reqc, ror);
    chk("t2_fault3", 32'(fault), 32'h4);
    chk("t2_result", 32'(result), 32'h4);
    round(4'hF, 4'hF, lat, reqc, ror);
    chk("t2_clr_fault", 32'(fault), 32'h0);
    chk("t2_clr_alive", 32'(alive), 32'hF);
    round(4'hF, 4'hB, lat, reqc, ror);
    round(4'hF, 4'hB, lat, reqc, ror);
    chk("t2_miss_cleared", 32'(fault), 32'h0);
    chk("t2_result7",      32'(result), 32'h7);

    // 3: partial mask, then empty mask; result wraps 7 -> 0
    round(4'h5, 4'h5, lat, reqc, ror);
    chk("t3_req_or",  32'(ror),    32'h5);
    chk("t3_alive",   32'(alive),  32'hF);
    chk("t3_fault",   32'(fault),  32'h0);
    chk("t3_lat",     32'(lat),    32'd3);
    chk("t3_wrap",    32'(result), 32'h0);
    round(4'h0, 4'h0, lat, reqc, ror);
    chk("t3_m0_lat",   32'(lat),    32'd3);
    chk("t3_m0_reqc",  32'(reqc),   32'd0);
    chk("t3_m0_alive", 32'(alive),  32'hF);
    chk("t3_m0_res",   32'(result), 32'h1);

    // disabled channel keeps its history; ch3 faults
    round(4'hF, 4'h7, lat, reqc, ror);
    round(4'hF, 4'h7, lat, reqc, ror);
    round(4'hF, 4'h7, lat, reqc, ror);
    chk("t5_pre_fault", 32'(fault),  32'h8);
    chk("t5_pre_alive", 32'(alive),  32'h7);
    chk("t5_pre_res",   32'(result), 32'h4);

    // 5: async reset during WAIT
    en_mask = 4'hF; ack = 4'h0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t5_wait_req", 32'(req), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req",    32'(req),    32'h0);
    chk("t5_rst_busy",   32'(busy),   32'h0);
    chk("t5_rst_done",   32'(done),   32'h0);
    chk("t5_rst_alive",  32'(alive),  32'h0);
    chk("t5_rst_fault",  32'(fault),  32'h0);
    chk("t5_rst_result", 32'(result), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_idle", 32'(busy), 32'h0);
    round(4'hF, 4'hF, lat, reqc, ror);
    chk("t5_post_lat", 32'(lat),    32'd3);
    chk("t5_post_res", 32'(result), 32'h1);

    // 4: auto launch right after reset release, start mid-round ignored
    auto_en = 1'b1; en_mask = 4'hF; ack = 4'hF;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_first_launch", 32'(busy), 32'h1);
    r1 = cyc;
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t4_done", 32'(done), 32'h1);
    tick();
    chk("t4_res1", 32'(result), 32'h1);
    tick();
    chk("t4_no_queue", 32'(busy), 32'h0);
    r2 = 0;
    for (int k = 0; k < 1200 && r2 == 0; k++) begin
      tick();
      if (busy) r2 = cyc;
    end
    chk("t4_second_launch", 32'(r2 != 0), 32'h1);
    chk("t4_gap_ok", 32'((r2 - r1 == PERIOD) || (r2 - r1 == PERIOD + 1)), 32'h1);
    auto_en = 1'b0;
    repeat (4) tick();
    chk("t4_res2", 32'(result), 32'h2);
    chk("t4_idle", 32'(busy),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
